// File: rtl/pixel_compositor.sv
// rtl/pixel_compositor.sv - final video stage: sync alignment, HUD/sprite/background layering, RGB332 expansion
module pixel_compositor #(
    parameter int         SPRITE_LAT = 2,
    parameter int         GROUND_Y   = 400,
    parameter logic [7:0] SKY_COLOR  = 8'h4F,
    parameter logic [7:0] GND_COLOR  = 8'h8C,
    parameter int         BAR_Y      = 16,
    parameter int         BAR_H      = 8,
    parameter int         BAR_SEG    = 20,
    parameter int         HEALTH_MAX = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] sprite_data,
    input  logic       sprite_visible,
    input  logic [3:0] health1,
    input  logic [3:0] health2,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank_n,
    output logic       frame_tick
);

    localparam int         LAST      = SPRITE_LAT - 1;
    localparam logic [9:0] GROUND_10 = 10'(GROUND_Y);
    localparam logic [9:0] BAR_TOP   = 10'(BAR_Y);
    localparam logic [9:0] BAR_BOT   = 10'(BAR_Y + BAR_H);
    localparam logic [9:0] SEG_10    = 10'(BAR_SEG);
    localparam logic [9:0] P1_LO     = 10'd16;
    localparam logic [9:0] P1_HI     = 10'(16 + HEALTH_MAX * BAR_SEG);
    localparam logic [9:0] P2_HI     = 10'd624;
    localparam logic [9:0] P2_LO     = 10'(624 - HEALTH_MAX * BAR_SEG);
    localparam logic [3:0] HMAX_4    = 4'(HEALTH_MAX);
    localparam logic [7:0] P1_COLOR  = 8'h1C;
    localparam logic [7:0] P2_COLOR  = 8'hE0;
    localparam logic [7:0] SLOT_GREY = 8'h49;

    logic [9:0] x_q   [SPRITE_LAT];
    logic [9:0] y_q   [SPRITE_LAT];
    logic       von_q [SPRITE_LAT];
    logic       hs_q  [SPRITE_LAT];
    logic       vs_q  [SPRITE_LAT];

    logic       vs_prev_q;
    logic [3:0] hlat1_q, hlat2_q;
    logic       frame_tick_q;
    logic       vs_fall;
    logic [3:0] h1_clamp, h2_clamp;

    logic [7:0] r_q, g_q, b_q;
    logic [7:0] r_d, g_d, b_d;
    logic       hsync_q, vsync_q, blank_n_q, blank_n_d;

    logic [9:0] xd, yd;
    logic       bar_row, p1_slot, p2_slot;
    logic [9:0] p1_end, p2_start;
    logic [7:0] color_d;

    // Coordinates and syncs wait here until the sprite stage catches up.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SPRITE_LAT; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                von_q[i] <= 1'b0;
                hs_q[i]  <= 1'b1;
                vs_q[i]  <= 1'b1;
            end
        end else begin
            x_q[0]   <= pixel_x;
            y_q[0]   <= pixel_y;
            von_q[0] <= video_on;
            hs_q[0]  <= hsync_in;
            vs_q[0]  <= vsync_in;
            for (int i = 1; i < SPRITE_LAT; i++) begin
                x_q[i]   <= x_q[i-1];
                y_q[i]   <= y_q[i-1];
                von_q[i] <= von_q[i-1];
                hs_q[i]  <= hs_q[i-1];
                vs_q[i]  <= vs_q[i-1];
            end
        end
    end

    assign vs_fall  = vs_prev_q & ~vsync_in;
    assign h1_clamp = (health1 > HMAX_4) ? HMAX_4 : health1;
    assign h2_clamp = (health2 > HMAX_4) ? HMAX_4 : health2;

    // Edge detector follows vsync_in even in reset so a level held low across reset is not an edge.
    always_ff @(posedge clk) begin
        vs_prev_q <= vsync_in;
        if (rst) begin
            hlat1_q      <= HMAX_4;
            hlat2_q      <= HMAX_4;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= vs_fall;
            if (vs_fall) begin
                hlat1_q <= h1_clamp;
                hlat2_q <= h2_clamp;
            end
        end
    end

    assign xd       = x_q[LAST];
    assign yd       = y_q[LAST];
    assign bar_row  = (yd >= BAR_TOP) && (yd < BAR_BOT);
    assign p1_slot  = bar_row && (xd >= P1_LO) && (xd < P1_HI);
    assign p2_slot  = bar_row && (xd >= P2_LO) && (xd < P2_HI);
    assign p1_end   = P1_LO + ({6'd0, hlat1_q} * SEG_10);
    assign p2_start = P2_HI - ({6'd0, hlat2_q} * SEG_10);

    always_comb begin
        color_d   = (yd >= GROUND_10) ? GND_COLOR : SKY_COLOR;
        r_d       = 8'h00;
        g_d       = 8'h00;
        b_d       = 8'h00;
        blank_n_d = 1'b0;
        if (sprite_visible) begin
            color_d = sprite_data;
        end
        if (p2_slot) begin
            color_d = (xd >= p2_start) ? P2_COLOR : SLOT_GREY;
        end
        if (p1_slot) begin
            color_d = (xd < p1_end) ? P1_COLOR : SLOT_GREY;
        end
        if (von_q[LAST]) begin
            r_d       = {color_d[7:5], color_d[7:5], color_d[7:6]};
            g_d       = {color_d[4:2], color_d[4:2], color_d[4:3]};
            b_d       = {color_d[1:0], color_d[1:0], color_d[1:0], color_d[1:0]};
            blank_n_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hsync_q   <= hs_q[LAST];
            vsync_q   <= vs_q[LAST];
            blank_n_q <= blank_n_d;
        end
    end

    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_n_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// tb/tb_pixel_compositor.sv - randomized and directed bench for pixel_compositor against a cycle history model
module tb_pixel_compositor;

    localparam int NMAX = 6000;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, hsync_in, vsync_in;
    logic [7:0] sprite_data;
    logic       sprite_visible;
    logic [3:0] health1, health2;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hsync, vga_vsync, vga_blank_n, frame_tick;

    pixel_compositor dut (
        .clk(clk), .rst(rst),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .sprite_data(sprite_data), .sprite_visible(sprite_visible),
        .health1(health1), .health2(health2),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // history of what was applied at each edge, plus latched health after that edge
    int hx [NMAX], hy [NMAX], hsd [NMAX], hl1 [NMAX], hl2 [NMAX];
    bit hvon [NMAX], hhs [NMAX], hvs [NMAX], hrst [NMAX], hsv [NMAX];
    int k = 0;

    bit g_rst = 1'b1, g_hs = 1'b1, g_vs = 1'b1;
    int g_h1 = 10, g_h2 = 10;
    int tick_cnt = 0, hs_low_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic int layer_color(int x, int y, int l1, int l2, bit sv, int sd);
        bit row;
        row = (y >= 16) && (y < 24);
        if (row && x >= 16 && x < 216) return (x < 16 + l1 * 20) ? 'h1C : 'h49;
        if (row && x >= 424 && x < 624) return (x >= 624 - l2 * 20) ? 'hE0 : 'h49;
        if (sv) return sd;
        return (y >= 400) ? 'h8C : 'h4F;
    endfunction

    function automatic logic [23:0] expand(int c);
        logic [7:0] v;
        v = c[7:0];
        return {v[7:5], v[7:5], v[7:6], v[4:2], v[4:2], v[4:3], v[1:0], v[1:0], v[1:0], v[1:0]};
    endfunction

    task automatic step(input int x, input int y, input bit von, input bit sv, input int sd);
        logic [23:0] e_rgb;
        bit          e_hs, e_vs, e_bl, e_tick, fall;
        int          j;
        rst = g_rst; pixel_x = x[9:0]; pixel_y = y[9:0]; video_on = von;
        hsync_in = g_hs; vsync_in = g_vs; sprite_visible = sv; sprite_data = sd[7:0];
        health1 = g_h1[3:0]; health2 = g_h2[3:0];
        hx[k] = x; hy[k] = y; hvon[k] = von; hhs[k] = g_hs; hvs[k] = g_vs;
        hrst[k] = g_rst; hsv[k] = sv; hsd[k] = sd;
        @(posedge clk);
        #1;
        e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_tick = 1'b0;
        if (hrst[k] || k == 0) begin
            hl1[k] = 10; hl2[k] = 10;
        end else begin
            fall = hvs[k-1] && !hvs[k];
            e_tick = fall;
            hl1[k] = fall ? ((g_h1 > 10) ? 10 : g_h1) : hl1[k-1];
            hl2[k] = fall ? ((g_h2 > 10) ? 10 : g_h2) : hl2[k-1];
            if (k >= 2 && !hrst[k-1] && !hrst[k-2]) begin
                j = k - 2;
                e_hs = hhs[j];
                e_vs = hvs[j];
                if (hvon[j]) begin
                    e_rgb = expand(layer_color(hx[j], hy[j], hl1[k-1], hl2[k-1], hsv[k], hsd[k]));
                    e_bl  = 1'b1;
                end
            end
        end
        check("rgb", {vga_r, vga_g, vga_b}, e_rgb);
        check("hsync", vga_hsync, e_hs);
        check("vsync", vga_vsync, e_vs);
        check("blank_n", vga_blank_n, e_bl);
        check("frame_tick", frame_tick, e_tick);
        if (frame_tick) tick_cnt++;
        if (!vga_hsync) hs_low_cnt++;
        k++;
    endtask

    task automatic idle();
        step(0, 0, 1'b0, 1'b0, 0);
    endtask

    // coords now, sprite data SPRITE_LAT cycles later; returns when the pixel is on the pins
    task automatic pix(input int x, input int y, input bit von, input bit sv, input int sd);
        step(x, y, von, 1'b0, 0);
        idle();
        step(0, 0, 1'b0, sv, sd);
    endtask

    task automatic frame_latch();
        g_vs = 1'b1; idle(); idle();
        g_vs = 1'b0; idle(); idle(); idle();
        g_vs = 1'b1; idle(); idle();
    endtask

    int bnd [10] = '{15, 16, 75, 76, 215, 216, 423, 424, 623, 624};

    initial begin
        int x, y;
        g_rst = 1'b1;
        idle();
        check("reset_rgb", {vga_r, vga_g, vga_b}, 24'h000000);
        check("reset_syncs", {vga_hsync, vga_vsync, vga_blank_n, frame_tick}, 4'b1100);
        idle(); idle();
        g_rst = 1'b0;
        idle(); idle(); idle();

        pix(100, 200, 1'b1, 1'b1, 'hE0);
        check("t1_sprite_red", {vga_r, vga_g, vga_b}, 24'hFF0000);
        check("t1_blank_n", vga_blank_n, 1'b1);

        pix(300, 399, 1'b1, 1'b0, 'h00);
        check("t2_sky", {vga_r, vga_g, vga_b}, 24'h496DFF);
        pix(300, 400, 1'b1, 1'b0, 'h00);
        check("t2_ground", {vga_r, vga_g, vga_b}, 24'h926D00);

        g_h1 = 3;
        frame_latch();
        pix(75, 16, 1'b1, 1'b0, 0);
        check("t3_x75_green", {vga_r, vga_g, vga_b}, 24'h00FF00);
        pix(76, 16, 1'b1, 1'b0, 0);
        check("t3_x76_grey", {vga_r, vga_g, vga_b}, 24'h494955);
        pix(216, 16, 1'b1, 1'b0, 0);
        check("t3_x216_bg", {vga_r, vga_g, vga_b}, 24'h496DFF);
        g_h1 = 8;
        pix(100, 16, 1'b1, 1'b0, 0);
        check("t3_no_tear", {vga_r, vga_g, vga_b}, 24'h494955);
        frame_latch();
        pix(100, 16, 1'b1, 1'b0, 0);
        check("t3_new_frame", {vga_r, vga_g, vga_b}, 24'h00FF00);

        g_h2 = 15;
        tick_cnt = 0;
        frame_latch();
        check("t4_one_tick", tick_cnt, 1);
        pix(424, 20, 1'b1, 1'b0, 0);
        check("t4_x424_red", {vga_r, vga_g, vga_b}, 24'hFF0000);
        pix(623, 23, 1'b1, 1'b0, 0);
        check("t4_x623_red", {vga_r, vga_g, vga_b}, 24'hFF0000);
        pix(423, 20, 1'b1, 1'b1, 'h1C);
        check("t4_x423_sprite", {vga_r, vga_g, vga_b}, 24'h00FF00);

        hs_low_cnt = 0;
        g_hs = 1'b0;
        repeat (96) step(50, 100, 1'b1, 1'b0, 0);
        g_hs = 1'b1;
        repeat (6) idle();
        check("t5_hsync_width", hs_low_cnt, 96);
        pix(100, 200, 1'b0, 1'b1, 'hE0);
        check("t5_off_rgb", {vga_r, vga_g, vga_b}, 24'h000000);
        check("t5_off_blank", vga_blank_n, 1'b0);

        repeat (4) step(100, 200, 1'b1, 1'b1, 'hE0);
        g_rst = 1'b1;
        step(100, 200, 1'b1, 1'b1, 'hE0);
        check("t6_rst_rgb", {vga_r, vga_g, vga_b}, 24'h000000);
        check("t6_rst_syncs", {vga_hsync, vga_vsync, vga_blank_n}, 3'b110);
        g_rst = 1'b0;
        pix(100, 200, 1'b1, 1'b1, 'hE0);
        check("t6_resume", {vga_r, vga_g, vga_b}, 24'hFF0000);

        for (int n = 0; n < 2500; n++) begin
            case ($urandom_range(0, 3))
                0:       x = bnd[$urandom_range(0, 9)];
                default: x = $urandom_range(0, 639);
            endcase
            case ($urandom_range(0, 5))
                0:       y = $urandom_range(14, 25);
                1:       y = $urandom_range(398, 401);
                default: y = $urandom_range(0, 479);
            endcase
            if ($urandom_range(0, 39) == 0) g_hs = ~g_hs;
            if ($urandom_range(0, 59) == 0) g_vs = ~g_vs;
            if ($urandom_range(0, 9) == 0) g_h1 = $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) g_h2 = $urandom_range(0, 15);
            g_rst = ($urandom_range(0, 199) == 0);
            step(x, y, ($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 255));
        end
        g_rst = 1'b0;
        idle(); idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
